// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared constants for the RTC bus sequencer: mode encodings, default slot and address values,
// and the sequencer state type.
package rtc_bus_sequencer_pkg;

    localparam logic [2:0] MODE_INIT   = 3'd0;
    localparam logic [2:0] MODE_REINIT = 3'd1;
    localparam logic [2:0] MODE_READ   = 3'd2;
    localparam logic [2:0] MODE_WR0    = 3'd3;

    localparam logic [6:0] SAFE_SLOT_DEF  = 7'h4A;
    localparam logic [7:0] ALM_BASE_DEF   = 8'h41;
    localparam logic [7:0] CLR_ADDR_DEF   = 8'h01;
    localparam logic [7:0] REINIT_END_DEF = 8'h02;

    typedef enum logic [1:0] {
        StInit,
        StReinit,
        StRead,
        StWrite
    } seq_state_e;

endpackage

// File: rtl/rtc_alarm_match.sv
// N-channel sticky alarm/timer-match flags, set from the read sweep and cleared either by the
// sweep's clear address or by every target being zero.
module rtc_alarm_match
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int unsigned    DW       = 8,
    parameter int unsigned    AW       = 8,
    parameter int unsigned    N_ALM    = 3,
    parameter logic [AW-1:0]  ALM_BASE = ALM_BASE_DEF,
    parameter logic [AW-1:0]  CLR_ADDR = CLR_ADDR_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                rd_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [N_ALM*DW-1:0] live_i,
    input  logic [N_ALM*DW-1:0] target_i,
    output logic [N_ALM-1:0]    flag_o
);

    logic [N_ALM-1:0] flag_q, flag_d;
    logic             any_tgt;

    assign any_tgt = |target_i;

    always_comb begin
        flag_d = flag_q;
        if (rd_i && any_tgt) begin
            for (int i = 0; i < N_ALM; i++) begin
                if (addr_i == ALM_BASE + AW'(i) &&
                    live_i[i*DW +: DW] == target_i[i*DW +: DW]) begin
                    flag_d[i] = 1'b1;
                end
            end
        end
        // Clear takes precedence over any set in the same cycle.
        if (!any_tgt || (rd_i && addr_i == CLR_ADDR)) begin
            flag_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Owner of the shared RTC bus: picks init, re-init, background read or a write mode, switching
// only at the protocol safe slot, and muxes address/data toward the protocol generator.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int unsigned       DW         = 8,
    parameter int unsigned       AW         = 8,
    parameter int unsigned       N_WR       = 3,
    parameter int unsigned       SLOT_W     = 7,
    parameter logic [SLOT_W-1:0] SAFE_SLOT  = SAFE_SLOT_DEF,
    parameter int unsigned       INIT_CYC   = 1034,
    parameter int unsigned       N_ALM      = 3,
    parameter logic [AW-1:0]     ALM_BASE   = ALM_BASE_DEF,
    parameter logic [AW-1:0]     CLR_ADDR   = CLR_ADDR_DEF,
    parameter logic [AW-1:0]     REINIT_END = REINIT_END_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                reinit_req_i,
    input  logic [N_WR-1:0]     wr_req_i,
    input  logic [SLOT_W-1:0]   slot_i,
    input  logic [AW-1:0]       init_addr_i,
    input  logic [DW-1:0]       init_data_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [DW-1:0]       wr_data_i,
    input  logic [N_ALM*DW-1:0] alm_live_i,
    input  logic [N_ALM*DW-1:0] alm_target_i,
    output logic [AW-1:0]       bus_addr_o,
    output logic [DW-1:0]       bus_data_o,
    output logic                rd_mode_o,
    output logic [2:0]          mode_o,
    output logic                init_busy_o,
    output logic [N_WR-1:0]     wr_grant_o,
    output logic [N_ALM-1:0]    alm_flag_o
);

    localparam int unsigned CW = $clog2(INIT_CYC);
    localparam int unsigned IW = (N_WR > 1) ? $clog2(N_WR) : 1;

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic          wr_found;
    logic [IW-1:0] wr_sel;

    // Lowest-numbered active write request wins.
    always_comb begin
        wr_found = 1'b0;
        wr_sel   = '0;
        for (int i = N_WR - 1; i >= 0; i--) begin
            if (wr_req_i[i]) begin
                wr_found = 1'b1;
                wr_sel   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_idx_d = wr_idx_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == CW'(INIT_CYC - 1)) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StReinit: begin
                if (!reinit_req_i && bus_addr_o == REINIT_END) begin
                    state_d = StRead;
                end
            end
            StRead, StWrite: begin
                if (slot_i == SAFE_SLOT) begin
                    if (reinit_req_i) begin
                        state_d = StReinit;
                    end else if (wr_found) begin
                        state_d  = StWrite;
                        wr_idx_d = wr_sel;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    always_comb begin
        bus_addr_o  = rd_addr_i;
        bus_data_o  = '0;
        rd_mode_o   = 1'b0;
        mode_o      = MODE_READ;
        init_busy_o = 1'b0;
        wr_grant_o  = '0;
        unique case (state_q)
            StInit, StReinit: begin
                bus_addr_o  = init_addr_i;
                bus_data_o  = init_data_i;
                mode_o      = (state_q == StInit) ? MODE_INIT : MODE_REINIT;
                init_busy_o = 1'b1;
            end
            StRead: begin
                rd_mode_o = 1'b1;
            end
            StWrite: begin
                bus_addr_o = wr_addr_i;
                bus_data_o = wr_data_i;
                mode_o     = MODE_WR0 + 3'(wr_idx_q);
                wr_grant_o = N_WR'(1) << wr_idx_q;
            end
            default: ;
        endcase
    end

    rtc_alarm_match #(
        .DW       (DW),
        .AW       (AW),
        .N_ALM    (N_ALM),
        .ALM_BASE (ALM_BASE),
        .CLR_ADDR (CLR_ADDR)
    ) u_alarm (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .rd_i     (state_q == StRead),
        .addr_i   (bus_addr_o),
        .live_i   (alm_live_i),
        .target_i (alm_target_i),
        .flag_o   (alm_flag_o)
    );

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: init timing, safe-slot arbitration, re-init exit,
// alarm flags and reset during a write.
module tb_rtc_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        reinit_req;
    logic [2:0]  wr_req;
    logic [6:0]  slot;
    logic [7:0]  init_addr, init_data, rd_addr, wr_addr, wr_data;
    logic [23:0] alm_live, alm_target;
    logic [7:0]  bus_addr, bus_data;
    logic        rd_mode, init_busy;
    logic [2:0]  mode, wr_grant, alm_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rtc_bus_sequencer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .reinit_req_i (reinit_req),
        .wr_req_i     (wr_req),
        .slot_i       (slot),
        .init_addr_i  (init_addr),
        .init_data_i  (init_data),
        .rd_addr_i    (rd_addr),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .alm_live_i   (alm_live),
        .alm_target_i (alm_target),
        .bus_addr_o   (bus_addr),
        .bus_data_o   (bus_data),
        .rd_mode_o    (rd_mode),
        .mode_o       (mode),
        .init_busy_o  (init_busy),
        .wr_grant_o   (wr_grant),
        .alm_flag_o   (alm_flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        reinit_req = 1'b0;
        wr_req     = '0;
        slot       = 7'h10;
        init_addr  = 8'h00;
        init_data  = 8'h3C;
        rd_addr    = 8'h55;
        wr_addr    = 8'hA0;
        wr_data    = 8'h5C;
        alm_live   = '0;
        alm_target = '0;

        // 1. reset and power-up init length
        step();
        step();
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_busy", 32'(init_busy), 32'd1);
        check_eq("rst_grant", 32'(wr_grant), 32'd0);
        check_eq("rst_flag", 32'(alm_flag), 32'd0);
        check_eq("rst_rdmode", 32'(rd_mode), 32'd0);
        reset = 1'b0;
        repeat (1033) step();
        check_eq("init_last_mode", 32'(mode), 32'd0);
        check_eq("init_last_busy", 32'(init_busy), 32'd1);
        step();
        check_eq("init_done_mode", 32'(mode), 32'd2);
        check_eq("read_rdmode", 32'(rd_mode), 32'd1);
        check_eq("read_addr", 32'(bus_addr), 32'h55);
        check_eq("read_data", 32'(bus_data), 32'h00);
        check_eq("read_busy", 32'(init_busy), 32'd0);

        // 2. write request admitted only at the safe slot
        wr_req = 3'b001;
        step();
        check_eq("unsafe_hold", 32'(mode), 32'd2);
        slot = 7'h4A;
        step();
        slot = 7'h10;
        check_eq("wr0_mode", 32'(mode), 32'd3);
        check_eq("wr0_grant", 32'(wr_grant), 32'b001);
        check_eq("wr0_data", 32'(bus_data), 32'h5C);
        check_eq("wr0_addr", 32'(bus_addr), 32'hA0);
        check_eq("wr0_rdmode", 32'(rd_mode), 32'd0);

        // 3. priority among writes, then re-init
        wr_req = 3'b110;
        step();
        check_eq("wr_hold_unsafe", 32'(mode), 32'd3);
        slot = 7'h4A;
        step();
        slot = 7'h10;
        check_eq("wr1_mode", 32'(mode), 32'd4);
        check_eq("wr1_grant", 32'(wr_grant), 32'b010);
        reinit_req = 1'b1;
        step();
        check_eq("reinit_unsafe", 32'(mode), 32'd4);
        slot = 7'h4A;
        step();
        slot = 7'h10;
        check_eq("reinit_mode", 32'(mode), 32'd1);
        check_eq("reinit_busy", 32'(init_busy), 32'd1);
        check_eq("reinit_addr", 32'(bus_addr), 32'h00);
        check_eq("reinit_data", 32'(bus_data), 32'h3C);

        // 4. re-init exits only at the end address once released
        reinit_req = 1'b0;
        wr_req     = '0;
        step();
        check_eq("reinit_a00", 32'(mode), 32'd1);
        init_addr = 8'h01;
        step();
        check_eq("reinit_a01", 32'(mode), 32'd1);
        init_addr = 8'h02;
        #1;
        check_eq("reinit_a02_addr", 32'(bus_addr), 32'h02);
        step();
        check_eq("reinit_exit", 32'(mode), 32'd2);

        // 5. sticky alarm set on channel 0, cleared at clear address
        alm_target = {8'h00, 8'h00, 8'h30};
        alm_live   = {8'h00, 8'h00, 8'h30};
        rd_addr    = 8'h41;
        step();
        check_eq("alm_set0", 32'(alm_flag), 32'b001);
        rd_addr = 8'h10;
        step();
        check_eq("alm_sticky", 32'(alm_flag), 32'b001);
        rd_addr = 8'h01;
        step();
        check_eq("alm_clr", 32'(alm_flag), 32'b000);

        // 6. zero targets never set; reset during a write
        alm_target = '0;
        alm_live   = '0;
        rd_addr    = 8'h42;
        step();
        check_eq("alm_zero_tgt", 32'(alm_flag), 32'b000);
        wr_req = 3'b001;
        slot   = 7'h4A;
        step();
        slot = 7'h10;
        check_eq("wr0_again", 32'(mode), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_in_wr_mode", 32'(mode), 32'd0);
        check_eq("rst_in_wr_grant", 32'(wr_grant), 32'd0);
        check_eq("rst_in_wr_busy", 32'(init_busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
